stopwatch_bcd_counter: RTL and testbench
========================================

Name: stopwatch_bcd_counter

Overview:
Stopwatch timebase and cascaded BCD counter, range 00.000 s to 59.999 s. Prescales the system clock to 1 ms ticks and accumulates five BCD digits: ms units, ms tens, ms hundreds, s units and s tens. Sits directly upstream of the 5-digit seven-segment decode stage; its digit outputs wire one-to-one to that stage's count, dec, cent, seg and seg_dec inputs. A start/stop and clear control FSM gates counting.

Parameters:
N, 4, width of each digit output; must be >= 4; bits above [3:0] driven 0.
TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clock); must be >= 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start_stop  input  1  debounced, clk-synchronous level; each rising edge toggles run/pause
clear  input  1  synchronous clear level; zeroes the time and returns to IDLE
count  output  N  ms units digit, 0-9
dec  output  N  ms tens digit, 0-9
cent  output  N  ms hundreds digit, 0-9
seg  output  N  seconds units digit, 0-9
seg_dec  output  N  seconds tens digit, 0-5
running  output  1  high while FSM in RUN
overflow  output  1  sticky; set on wrap 59.999 -> 00.000

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE; all digits 0; prescaler 0; running=0; overflow=0; start_stop edge register loaded with 1. A start_stop held high through reset release does not start the counter.
- Edge detect: start_stop_q <= start_stop every cycle. start_edge = start_stop & ~start_stop_q. Only start_edge acts; level is ignored.
- FSM states:
  - IDLE: digits 0, prescaler 0. start_edge -> RUN.
  - RUN: prescaler counts. start_edge -> PAUSE.
  - PAUSE: prescaler and digits hold. start_edge -> RUN; prescaler resumes from its held value, no restart.
- Priority per cycle: rst > clear > start_edge > tick.
- clear=1 in any state: next state IDLE; digits, prescaler and overflow go to 0. A start_edge in the same cycle is discarded. While clear is held, the FSM stays in IDLE.
- Prescaler runs 0..TICK_DIV-1, only in RUN. On an edge with prescaler==TICK_DIV-1 in RUN, prescaler <= 0 and the ms units digit advances at that same edge.
- First increment lands TICK_DIV clock edges after the edge that entered RUN.
- A start_edge on the tick cycle takes priority: FSM -> PAUSE, no increment, prescaler holds at TICK_DIV-1. On resume, the increment occurs on the first RUN edge.
- Digit cascade, all on the same edge as the tick:
  - count 9 -> 0 carries into dec.
  - dec 9 -> 0 carries into cent.
  - cent 9 -> 0 carries into seg.
  - seg 9 -> 0 carries into seg_dec.
  - seg_dec 5 with carry -> 0: all digits read 0 and overflow <= 1. Counting continues in RUN.
- Digits never exceed 9 (seg_dec never exceeds 5). No illegal BCD codes are reachable.
- Outputs are registered; no combinational path from inputs to outputs.
- running = (state==RUN), registered with the state.
- overflow clears only on rst or clear.

Test Plan:
- Reset: rst=1 for 2 cycles with start_stop=1, then rst=0 and start_stop held at 1 for 20 cycles -> all digits 0, running=0, overflow=0 throughout.
- Basic count (TICK_DIV=4): start_stop 0->1 edge, run 40 clocks -> count=0, dec=1, others 0, running=1. First count change occurs exactly 4 edges after RUN entry.
- Pause/resume (TICK_DIV=4): run 10 clocks, second start_stop edge, wait 100 clocks -> digits frozen at count=2. Third edge -> counting resumes; next increment occurs after remaining prescaler cycles (2 edges).
- Full cascade (TICK_DIV=2): run 1000 ticks -> seg=1, cent=dec=count=0. Run to 59999 ticks -> 5,9,9,9,9. One more tick -> all 0, overflow=1, running=1.
- Clear priority: in RUN with digits nonzero, assert clear and a start_stop rising edge on the same cycle -> next cycle IDLE, digits 0, overflow 0, running 0. A later single edge starts from 00.000.
- Reset mid-run: rst=1 for 1 cycle while RUN at 12.345 -> next cycle all digits 0, IDLE, prescaler 0. No increments until a new start_edge.

Source files
------------

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timebase and cascaded BCD counter, 00.000 s to 59.999 s.
// A prescaler divides clk down to 1 ms ticks. Each tick advances five BCD
// digits: ms units, ms tens, ms hundreds, s units and s tens. A start/stop
// toggle FSM (IDLE / RUN / PAUSE) gates counting, and clear returns to IDLE.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start_stop clk-synchronous level; each rising edge toggles run/pause
//   clear      synchronous clear; zeroes time and overflow, forces IDLE
//   count      ms units digit (0-9)
//   dec        ms tens digit (0-9)
//   cent       ms hundreds digit (0-9)
//   seg        seconds units digit (0-9)
//   seg_dec    seconds tens digit (0-5)
//   running    high while the FSM is in RUN
//   overflow   sticky flag, set on the 59.999 -> 00.000 wrap
module stopwatch_bcd_counter #(
  parameter int N        = 4,
  parameter int TICK_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_stop,
  input  logic         clear,
  output logic [N-1:0] count,
  output logic [N-1:0] dec,
  output logic [N-1:0] cent,
  output logic [N-1:0] seg,
  output logic [N-1:0] seg_dec,
  output logic         running,
  output logic         overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int             PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);

  state_t          state;
  state_t          state_next;
  logic            running_next;
  logic            start_stop_q;
  logic            start_edge;
  logic            pre_en;
  logic            tick;
  logic [PW-1:0]   prescaler;
  logic [3:0]      d_ms1;
  logic [3:0]      d_ms10;
  logic [3:0]      d_ms100;
  logic [3:0]      d_s1;
  logic [3:0]      d_s10;

  // The edge register powers up as 1 so a level held high across reset
  // release is not mistaken for a start request.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) start_stop_q <= 1'b1;
    else     start_stop_q <= start_stop;
  end

  assign start_edge = start_stop & ~start_stop_q;

  // State register; running is registered alongside the state it reflects.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= running_next;
    end
  end

  // Next-state logic. clear outranks start_edge, so an edge arriving in the
  // same cycle as clear is dropped.
  // NOTE: every combinationally assigned signal gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (start_edge) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output / control decode. A start_edge in RUN pauses without advancing
  // the prescaler, even on the tick cycle, so the pending tick fires on the
  // first edge after resuming.
  always_comb begin
    running_next = (state_next == RUN);
    pre_en       = (state == RUN) && !clear && !start_edge;
    tick         = pre_en && (prescaler == PRE_MAX);
  end

  // Prescaler and digit cascade. All carries resolve on the tick edge.
  // NOTE: the digits are a handful of flops, not a memory, so they take the
  // synchronous reset like any other state.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prescaler <= '0;
      d_ms1     <= 4'd0;
      d_ms10    <= 4'd0;
      d_ms100   <= 4'd0;
      d_s1      <= 4'd0;
      d_s10     <= 4'd0;
      overflow  <= 1'b0;
    end else if (pre_en) begin
      if (tick) begin
        prescaler <= '0;
        if (d_ms1 != 4'd9) begin
          d_ms1 <= d_ms1 + 4'd1;
        end else begin
          d_ms1 <= 4'd0;
          if (d_ms10 != 4'd9) begin
            d_ms10 <= d_ms10 + 4'd1;
          end else begin
            d_ms10 <= 4'd0;
            if (d_ms100 != 4'd9) begin
              d_ms100 <= d_ms100 + 4'd1;
            end else begin
              d_ms100 <= 4'd0;
              if (d_s1 != 4'd9) begin
                d_s1 <= d_s1 + 4'd1;
              end else begin
                d_s1 <= 4'd0;
                if (d_s10 != 4'd5) begin
                  d_s10 <= d_s10 + 4'd1;
                end else begin
                  // 59.999 -> 00.000: flag it and keep counting.
                  d_s10    <= 4'd0;
                  overflow <= 1'b1;
                end
              end
            end
          end
        end
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

  // Digits are 4-bit BCD internally; any upper output bits read 0.
  assign count   = N'(d_ms1);
  assign dec     = N'(d_ms10);
  assign cent    = N'(d_ms100);
  assign seg     = N'(d_s1);
  assign seg_dec = N'(d_s10);

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Self-checking bench for stopwatch_bcd_counter.
// dut_a: TICK_DIV=4, N=6 (checks upper digit bits stay 0) for control and
// timing corners. dut_b: TICK_DIV=2, N=4 for the full cascade and wrap.
// Both share clk and inputs; each expectation names the instance it checks.
// Expected times are elapsed milliseconds, turned into digits by division.
module tb_stopwatch_bcd_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_stop = 1'b1;
  logic clear = 1'b0;

  logic [5:0] a_count, a_dec, a_cent, a_seg, a_seg_dec;
  logic       a_running, a_overflow;
  logic [3:0] b_count, b_dec, b_cent, b_seg, b_seg_dec;
  logic       b_running, b_overflow;

  always #5 clk = ~clk;

  stopwatch_bcd_counter #(.N(6), .TICK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
    .count(a_count), .dec(a_dec), .cent(a_cent), .seg(a_seg),
    .seg_dec(a_seg_dec), .running(a_running), .overflow(a_overflow)
  );

  stopwatch_bcd_counter #(.N(4), .TICK_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
    .count(b_count), .dec(b_dec), .cent(b_cent), .seg(b_seg),
    .seg_dec(b_seg_dec), .running(b_running), .overflow(b_overflow)
  );

  typedef struct {
    bit rst;
    bit ss;
    bit clr;
    int n;       // cycles to hold these inputs
    bit each;    // check after every cycle, not only the last
    int ms;      // expected elapsed time in ms on dut_a
    bit run;
    bit ovf;
  } vec_t;

  typedef struct {
    string name;
    bit    sel;  // 0: dut_a, 1: dut_b
    int    ms;
    bit    run;
    bit    ovf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(bit r, bit s, bit c, int n, bit each,
                              int ms, bit run, bit ovf);
    vec_t v;
    v.rst = r; v.ss = s; v.clr = c; v.n = n; v.each = each;
    v.ms = ms; v.run = run; v.ovf = ovf;
    return v;
  endfunction

  function automatic logic [39:0] bcd(int ms);
    return {8'(ms / 10000), 8'((ms / 1000) % 10), 8'((ms / 100) % 10),
            8'((ms / 10) % 10), 8'(ms % 10)};
  endfunction

  task automatic check(string name, logic [39:0] act, logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic compare();
    exp_t        e;
    logic [39:0] digits;
    logic        run_act;
    logic        ovf_act;
    e = sb.pop_front();
    if (e.sel) begin
      digits  = {8'(b_seg_dec), 8'(b_seg), 8'(b_cent), 8'(b_dec), 8'(b_count)};
      run_act = b_running;
      ovf_act = b_overflow;
    end else begin
      digits  = {8'(a_seg_dec), 8'(a_seg), 8'(a_cent), 8'(a_dec), 8'(a_count)};
      run_act = a_running;
      ovf_act = a_overflow;
    end
    check({e.name, ".digits"},   digits,          bcd(e.ms));
    check({e.name, ".running"},  40'(run_act),    40'(e.run));
    check({e.name, ".overflow"}, 40'(ovf_act),    40'(e.ovf));
  endtask

  // Holds inputs for n cycles; expectations are queued as stimulus is
  // driven and popped once the edge has produced the outputs.
  task automatic seq(string name, bit sel, bit r, bit s, bit c, int n,
                     bit each, int ms, bit run, bit ovf);
    for (int k = 0; k < n; k++) begin
      bit chk;
      rst        = r;
      start_stop = s;
      clear      = c;
      chk        = each || (k == n - 1);
      if (chk) sb.push_back('{name, sel, ms, run, ovf});
      @(posedge clk);
      @(negedge clk);
      if (chk) compare();
    end
  endtask

  initial begin
    // rst ss clr n each ms run ovf   (dut_a, TICK_DIV=4)
    vecs.push_back(mk(1, 1, 0,   2, 1,  0, 0, 0)); // 0 reset, ss high
    vecs.push_back(mk(0, 1, 0,  20, 1,  0, 0, 0)); // 1 ss held high: no start
    vecs.push_back(mk(0, 0, 0,   1, 0,  0, 0, 0)); // 2
    vecs.push_back(mk(0, 1, 0,   1, 0,  0, 1, 0)); // 3 edge -> RUN (E0)
    vecs.push_back(mk(0, 1, 0,   3, 1,  0, 1, 0)); // 4 E1..E3 no change
    vecs.push_back(mk(0, 1, 0,   1, 0,  1, 1, 0)); // 5 E4 first increment
    vecs.push_back(mk(0, 1, 0,  36, 0, 10, 1, 0)); // 6 E40: dec=1 count=0
    vecs.push_back(mk(0, 0, 0,   2, 0, 10, 1, 0)); // 7 prescaler -> 2
    vecs.push_back(mk(0, 1, 0,   1, 0, 10, 0, 0)); // 8 pause
    vecs.push_back(mk(0, 1, 0, 100, 1, 10, 0, 0)); // 9 frozen
    vecs.push_back(mk(0, 0, 0,   1, 0, 10, 0, 0)); // 10
    vecs.push_back(mk(0, 1, 0,   1, 0, 10, 1, 0)); // 11 resume
    vecs.push_back(mk(0, 1, 0,   1, 0, 10, 1, 0)); // 12
    vecs.push_back(mk(0, 1, 0,   1, 0, 11, 1, 0)); // 13 2nd edge after resume
    vecs.push_back(mk(0, 0, 0,   3, 0, 11, 1, 0)); // 14 prescaler -> 3
    vecs.push_back(mk(0, 1, 0,   1, 0, 11, 0, 0)); // 15 edge on tick cycle
    vecs.push_back(mk(0, 0, 0,   1, 0, 11, 0, 0)); // 16
    vecs.push_back(mk(0, 1, 0,   1, 0, 11, 1, 0)); // 17 resume
    vecs.push_back(mk(0, 1, 0,   1, 0, 12, 1, 0)); // 18 first RUN edge ticks
    vecs.push_back(mk(0, 0, 0,   1, 0, 12, 1, 0)); // 19
    vecs.push_back(mk(0, 1, 1,   1, 0,  0, 0, 0)); // 20 clear beats edge
    vecs.push_back(mk(0, 0, 1,   1, 0,  0, 0, 0)); // 21
    vecs.push_back(mk(0, 1, 1,   1, 0,  0, 0, 0)); // 22 held clear: IDLE
    vecs.push_back(mk(0, 1, 0,   3, 1,  0, 0, 0)); // 23 level only
    vecs.push_back(mk(0, 0, 0,   1, 0,  0, 0, 0)); // 24
    vecs.push_back(mk(0, 1, 0,   1, 0,  0, 1, 0)); // 25 start from 00.000
    vecs.push_back(mk(0, 1, 0,   4, 0,  1, 1, 0)); // 26
    vecs.push_back(mk(0, 1, 0,  20, 0,  6, 1, 0)); // 27
    vecs.push_back(mk(1, 1, 0,   1, 0,  0, 0, 0)); // 28 reset mid-run
    vecs.push_back(mk(0, 1, 0,  10, 1,  0, 0, 0)); // 29 stays idle
    vecs.push_back(mk(0, 0, 0,   1, 0,  0, 0, 0)); // 30
    vecs.push_back(mk(0, 1, 0,   1, 0,  0, 1, 0)); // 31 restart
    vecs.push_back(mk(0, 1, 0,   3, 0,  0, 1, 0)); // 32 prescaler from 0
    vecs.push_back(mk(0, 1, 0,   1, 0,  1, 1, 0)); // 33

    @(negedge clk);
    foreach (vecs[i]) begin
      seq($sformatf("v%0d", i), 1'b0, vecs[i].rst, vecs[i].ss, vecs[i].clr,
          vecs[i].n, vecs[i].each, vecs[i].ms, vecs[i].run, vecs[i].ovf);
    end

    // Full cascade and wrap on dut_b (TICK_DIV=2): one ms per two edges.
    seq("b_clear",  1'b1, 0, 1, 1,      1, 0,     0, 0, 0);
    seq("b_low",    1'b1, 0, 0, 0,      1, 0,     0, 0, 0);
    seq("b_start",  1'b1, 0, 1, 0,      1, 0,     0, 1, 0);
    seq("b_1s",     1'b1, 0, 1, 0,   2000, 0,  1000, 1, 0);
    seq("b_max",    1'b1, 0, 1, 0, 117998, 0, 59999, 1, 0);
    seq("b_hold",   1'b1, 0, 1, 0,      1, 0, 59999, 1, 0);
    seq("b_wrap",   1'b1, 0, 1, 0,      1, 0,     0, 1, 1);
    seq("b_sticky", 1'b1, 0, 1, 0,      2, 0,     1, 1, 1);
    seq("b_clr",    1'b1, 0, 1, 1,      1, 0,     0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
